// File: rtl/miner_work_ctrl_if.sv
// Host-side handshake bundle for miner_work_ctrl: work word stream in, result FIFO out.
// res_tag exists only when RESULT_TAG_EN is defined.
interface miner_work_ctrl_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_nonce;
`ifdef RESULT_TAG_EN
    logic [7:0]  res_tag;

    modport master (
        output wr_valid, wr_data, res_ready,
        input  wr_ready, res_valid, res_nonce, res_tag
    );

    modport slave (
        input  wr_valid, wr_data, res_ready,
        output wr_ready, res_valid, res_nonce, res_tag
    );
`else
    modport master (
        output wr_valid, wr_data, res_ready,
        input  wr_ready, res_valid, res_nonce
    );

    modport slave (
        input  wr_valid, wr_data, res_ready,
        output wr_ready, res_valid, res_nonce
    );
`endif
endinterface

// File: rtl/miner_work_ctrl.sv
// Double-buffered work loader and nonce result collector for one miner core.
// Optional RESULT_TAG_EN adds an 8-bit work id to every result entry.
module miner_work_ctrl #(
    parameter logic [31:0] CORES        = 32'd1,
    parameter logic [31:0] CORE_ID      = 32'd0,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          RST_CYCLES   = 4,
    parameter int          GUARD_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    miner_work_ctrl_if.slave    host,
    output logic [639:0]        miner_block,
    output logic [31:0]         miner_nonce_start,
    output logic                miner_reset,
    input  logic                miner_nonce_found,
    input  logic [31:0]         miner_nonce_out,
    output logic                busy,
    output logic                overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = $clog2(RST_CYCLES);
    localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
`ifdef RESULT_TAG_EN
    localparam int EW = 40;
`else
    localparam int EW = 32;
`endif

    if (CORES == 32'd0 || CORE_ID >= CORES) begin : g_bad_core_id
        $error("miner_work_ctrl: CORE_ID must be below CORES");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("miner_work_ctrl: FIFO_DEPTH must be a power of 2, >= 2");
    end
    if (RST_CYCLES < 2) begin : g_bad_rst
        $error("miner_work_ctrl: RST_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        START,
        RUN
    } state_t;

    state_t              state;
    logic [4:0]          count;
    logic [RW-1:0]       rst_cnt;
    logic [GW-1:0]       guard;
    logic                wr_ready;
    logic [19:0][31:0]   shadow;
    logic                accept;
    logic                last_word;

    assign accept    = host.wr_valid & wr_ready;
    assign last_word = (count == 5'd20);
    assign host.wr_ready = wr_ready;

`ifdef RESULT_TAG_EN
    logic [7:0] work_id;
`endif

    // Word 0 lands in the top slot so the packed shadow is already in block order.
    always_ff @(posedge clk) begin
        if (!reset && accept && !last_word) begin
            shadow[5'd19 - count] <= host.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            count             <= 5'd0;
            rst_cnt           <= '0;
            guard             <= '0;
            wr_ready          <= 1'b1;
            busy              <= 1'b0;
            miner_block       <= '0;
            miner_nonce_start <= '0;
            miner_reset       <= 1'b1;
`ifdef RESULT_TAG_EN
            work_id           <= 8'd0;
`endif
        end else begin
            if (guard != '0) begin
                guard <= guard - GW'(1);
            end
            unique case (state)
                IDLE, LOAD, RUN: begin
                    if (accept) begin
                        if (last_word) begin
                            state             <= START;
                            count             <= 5'd0;
                            rst_cnt           <= RW'(RST_CYCLES - 1);
                            wr_ready          <= 1'b0;
                            busy              <= 1'b1;
                            miner_block       <= shadow;
                            miner_nonce_start <= host.wr_data + CORE_ID;
                            miner_reset       <= 1'b1;
`ifdef RESULT_TAG_EN
                            work_id           <= work_id + 8'd1;
`endif
                        end else begin
                            state <= LOAD;
                            count <= count + 5'd1;
                            busy  <= 1'b0;
                        end
                    end
                end
                START: begin
                    if (rst_cnt == '0) begin
                        state       <= RUN;
                        wr_ready    <= 1'b1;
                        miner_reset <= 1'b0;
                        guard       <= GW'(GUARD_CYCLES);
                    end else begin
                        rst_cnt <= rst_cnt - RW'(1);
                    end
                end
            endcase
        end
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          push_req;
    logic          push;
    logic          pop;
    logic [EW-1:0] entry;
    logic [EW-1:0] head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Reports near a core restart may belong to the old work, so they are masked.
    assign push_req = miner_nonce_found & ~miner_reset & (guard == '0);
    assign pop      = ~empty & host.res_ready;
    assign push     = push_req & (~full | pop);
    assign head     = mem[rd_ptr[AW-1:0]];

`ifdef RESULT_TAG_EN
    assign entry        = {work_id, miner_nonce_out};
    assign host.res_tag = head[39:32];
`else
    assign entry        = miner_nonce_out;
`endif

    assign host.res_valid = ~empty;
    assign host.res_nonce = head[31:0];

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr[AW-1:0]] <= entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
